// File: rtl/rubiks_stream_rx_if.sv
// Cube-state serial link: the line input plus the decoded orientation word and its status strobes.
interface rubiks_stream_rx_if #(
    parameter int NBITS = 162
);
    logic             datastream;
    logic [NBITS-1:0] orientation;
    logic             valid;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic             color_err;

    modport master (
        output datastream,
        input  orientation, valid, busy, frame_err, parity_err, color_err
    );

    modport slave (
        input  datastream,
        output orientation, valid, busy, frame_err, parity_err, color_err
    );
endinterface

// File: rtl/rubiks_stream_rx.sv
// Receives one framed NBITS-bit orientation word (start, data MSB-first, even parity, stop)
// and presents it in parallel after framing, parity and colour-code checks.
module rubiks_stream_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NBITS        = 162
) (
    input  logic              clk,
    input  logic              reset,
    rubiks_stream_rx_if.slave bus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(NBITS + 1);
    localparam int NF = NBITS / 3;
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, EVAL, BREAK
    } state_e;

    state_e           state_q, state_d;
    logic             sync_q, rx_q;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] orient_q, orient_d;
    logic             par_q, par_d;
    logic             mism_q, mism_d;
    logic             stop_q, stop_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             cerr_q, cerr_d;
    logic             bad_color;

    // Codes 6 and 7 are the only ones with both upper bits set.
    always_comb begin
        bad_color = 1'b0;
        for (int unsigned k = 0; k < NF; k++) begin
            if (shift_q[3*k+1 +: 2] == 2'b11) bad_color = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        orient_d = orient_q;
        par_d    = par_q;
        mism_d   = mism_q;
        stop_d   = stop_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        cerr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (!rx_q) state_d = START;
            end
            START: begin
                if (tmr_q == HALF_M1) begin
                    tmr_d   = '0;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    state_d = rx_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tmr_q == FULL_M1) begin
                    tmr_d   = '0;
                    shift_d = {shift_q[NBITS-2:0], rx_q};
                    par_d   = par_q ^ rx_q;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tmr_q == FULL_M1) begin
                    tmr_d   = '0;
                    mism_d  = par_q ^ rx_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tmr_q == FULL_M1) begin
                    tmr_d   = '0;
                    stop_d  = rx_q;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Decision is one cycle after the stop sample, in error-priority order.
                tmr_d = '0;
                if (!stop_q) begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end else if (mism_q) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else if (bad_color) begin
                    cerr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    orient_d = shift_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            BREAK: begin
                tmr_d = '0;
                if (rx_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= 1'b1;
            rx_q     <= 1'b1;
            state_q  <= IDLE;
            tmr_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            orient_q <= '0;
            par_q    <= 1'b0;
            mism_q   <= 1'b0;
            stop_q   <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            sync_q   <= bus.datastream;
            rx_q     <= sync_q;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            orient_q <= orient_d;
            par_q    <= par_d;
            mism_q   <= mism_d;
            stop_q   <= stop_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            cerr_q   <= cerr_d;
        end
    end

    assign bus.orientation = orient_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_err   = ferr_q;
    assign bus.parity_err  = perr_q;
    assign bus.color_err   = cerr_q;
endmodule
